// File: rtl/cond_unit.sv
// Architectural NZCV flag register plus ARM condition evaluation; latches the
// condition outcome at decode and gates the controller's PC/register/memory writes.
module cond_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       CondLatch,
  input  logic       PCS,
  input  logic       NextPC,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  output logic [3:0] Flags,
  output logic       CondEx,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite
);

  typedef enum logic [3:0] {
    C_EQ = 4'b0000,
    C_NE = 4'b0001,
    C_CS = 4'b0010,
    C_CC = 4'b0011,
    C_MI = 4'b0100,
    C_PL = 4'b0101,
    C_VS = 4'b0110,
    C_VC = 4'b0111,
    C_HI = 4'b1000,
    C_LS = 4'b1001,
    C_GE = 4'b1010,
    C_LT = 4'b1011,
    C_GT = 4'b1100,
    C_LE = 4'b1101,
    C_AL = 4'b1110,
    C_NV = 4'b1111
  } cond_e;

  logic       n, z, c, v;
  logic       pass;
  logic [1:0] flagwrite;

  assign {n, z, c, v} = Flags;

  // Evaluated against the registered flags, so a same-cycle flag write is not seen.
  always_comb begin
    pass = 1'b0;
    case (cond_e'(Cond))
      C_EQ: pass = z;
      C_NE: pass = ~z;
      C_CS: pass = c;
      C_CC: pass = ~c;
      C_MI: pass = n;
      C_PL: pass = ~n;
      C_VS: pass = v;
      C_VC: pass = ~v;
      C_HI: pass = c & ~z;
      C_LS: pass = ~c | z;
      C_GE: pass = (n == v);
      C_LT: pass = (n != v);
      C_GT: pass = ~z & (n == v);
      C_LE: pass = z | (n != v);
      C_AL: pass = 1'b1;
      C_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

  assign flagwrite = FlagW & {2{CondEx}};

  always_ff @(posedge clk) begin
    if (!reset) begin
      CondEx <= 1'b0;
    end else if (CondLatch) begin
      CondEx <= pass;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      Flags <= '0;
    end else begin
      if (flagwrite[1]) Flags[3:2] <= ALUFlags[3:2];
      if (flagwrite[0]) Flags[1:0] <= ALUFlags[1:0];
    end
  end

  assign PCWrite  = NextPC | (PCS & CondEx);
  assign RegWrite = RegW & CondEx & ~NoWrite;
  assign MemWrite = MemW & CondEx;

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: directed scenarios plus randomized stimulus
// compared against a behavioural flag/condition model.
module tb_cond_unit;

  logic       clk;
  logic       reset;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       CondLatch;
  logic       PCS;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       NoWrite;
  logic [3:0] Flags;
  logic       CondEx;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // reference state
  logic [3:0] m_flags;
  logic       m_condex;

  cond_unit dut (
    .clk      (clk),
    .reset    (reset),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .CondLatch(CondLatch),
    .PCS      (PCS),
    .NextPC   (NextPC),
    .RegW     (RegW),
    .MemW     (MemW),
    .NoWrite  (NoWrite),
    .Flags    (Flags),
    .CondEx   (CondEx),
    .PCWrite  (PCWrite),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b expected=%b at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Condition codes come in complementary pairs: odd code = negation of even one.
  function automatic logic ref_pass(input logic [3:0] f, input logic [3:0] cc);
    logic fn, fz, fc, fv, base;
    {fn, fz, fc, fv} = f;
    case (cc >> 1)
      0: base = fz;
      1: base = fc;
      2: base = fn;
      3: base = fv;
      4: base = fc && !fz;
      5: base = (fn == fv);
      6: base = !fz && (fn == fv);
      default: base = 1'b1;
    endcase
    return cc[0] ? !base : base;
  endfunction

  task automatic drive(input logic r, input logic [3:0] cc, input logic [3:0] alu,
                       input logic [1:0] fw, input logic cl, input logic pcs,
                       input logic npc, input logic rw, input logic mw, input logic nw);
    reset = r; Cond = cc; ALUFlags = alu; FlagW = fw; CondLatch = cl;
    PCS = pcs; NextPC = npc; RegW = rw; MemW = mw; NoWrite = nw;
  endtask

  // Checks gated strobes before the edge, then advances the model and checks state.
  task automatic tick();
    logic       nxt_condex;
    logic [3:0] nxt_flags;
    #1;
    check("pcwrite",  {3'b0, PCWrite},  {3'b0, NextPC || (PCS && m_condex)});
    check("regwrite", {3'b0, RegWrite}, {3'b0, RegW && m_condex && !NoWrite});
    check("memwrite", {3'b0, MemWrite}, {3'b0, MemW && m_condex});
    @(posedge clk);
    if (!reset) begin
      nxt_flags  = 4'b0000;
      nxt_condex = 1'b0;
    end else begin
      nxt_flags  = m_flags;
      nxt_condex = CondLatch ? ref_pass(m_flags, Cond) : m_condex;
      if (FlagW[1] && m_condex) nxt_flags[3:2] = ALUFlags[3:2];
      if (FlagW[0] && m_condex) nxt_flags[1:0] = ALUFlags[1:0];
    end
    m_flags  = nxt_flags;
    m_condex = nxt_condex;
    #1;
    check("flags",  Flags, m_flags);
    check("condex", {3'b0, CondEx}, {3'b0, m_condex});
  endtask

  initial begin
    m_flags  = 4'b0000;
    m_condex = 1'b0;

    // Reset beats CondLatch and FlagW on the same edge.
    drive(1'b0, 4'b1110, 4'b1111, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    check("rst_flags",  Flags, 4'b0000);
    check("rst_condex", {3'b0, CondEx}, 4'b0000);
    check("rst_regw",   {3'b0, RegWrite}, 4'b0000);
    check("rst_memw",   {3'b0, MemWrite}, 4'b0000);

    // Condition sweep over all flag values and all codes.
    for (int f = 0; f < 16; f++) begin
      for (int cc = 0; cc < 16; cc++) begin
        drive(1'b1, 4'b1110, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'b1110, 4'(f), 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("sweep_flags", Flags, 4'(f));
        drive(1'b1, 4'(cc), 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        if (f == 4 && cc == 0)  check("ex_eq",  {3'b0, CondEx}, 4'b0001);
        if (f == 8 && cc == 10) check("ex_ge",  {3'b0, CondEx}, 4'b0000);
        if (cc == 15)           check("ex_nv",  {3'b0, CondEx}, 4'b0000);
        if (cc == 14)           check("ex_al",  {3'b0, CondEx}, 4'b0001);
      end
    end

    // Split flag write: halves update independently.
    drive(1'b0, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'b1110, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'b1110, 4'b1111, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("split_nz", Flags, 4'b1100);
    drive(1'b1, 4'b1110, 4'b0011, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("split_cv", Flags, 4'b1111);

    // Failed condition suppresses all gated writes and flag updates.
    drive(1'b0, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("fail_condex", {3'b0, CondEx}, 4'b0000);
    drive(1'b1, 4'b0000, 4'b1111, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    #1;
    check("fail_regw", {3'b0, RegWrite}, 4'b0000);
    check("fail_memw", {3'b0, MemWrite}, 4'b0000);
    check("fail_pcw",  {3'b0, PCWrite},  4'b0000);
    tick();
    check("fail_flags", Flags, 4'b0000);

    // Compare-class op: flags written, register write suppressed.
    drive(1'b1, 4'b1110, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'b1110, 4'b0110, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    #1;
    check("cmp_regw", {3'b0, RegWrite}, 4'b0000);
    tick();
    check("cmp_flags", Flags, 4'b0110);
    drive(1'b1, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("cmp_eq", {3'b0, CondEx}, 4'b0001);

    // Same-cycle latch and flag write: latch sees old flags.
    drive(1'b0, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'b1110, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'b0000, 4'b0100, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("haz_flags",  Flags, 4'b0100);
    check("haz_condex", {3'b0, CondEx}, 4'b0000);
    drive(1'b1, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("haz_relatch", {3'b0, CondEx}, 4'b0001);

    // Mid-instruction reset kills gated writes but NextPC passes.
    drive(1'b0, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    check("midrst_pcw", {3'b0, PCWrite}, 4'b0001);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 49) != 0), 4'($urandom), 4'($urandom), 2'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
